// File: rtl/cache_def.sv
// Shared cache definitions: default tag-array geometry, stored entry layout and tag-array FSM states.
package cache_def;

  localparam int DEF_WAYS  = 8;
  localparam int DEF_SETS  = 1024;
  localparam int DEF_TAG_W = 18;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [DEF_TAG_W-1:0] tag;
  } cache_tag_type;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } tag_state_e;

endpackage

// File: rtl/l2_tag_array_nway_if.sv
// Request/response/flush bundle of the L2 tag array; master drives requests, slave is the array.
interface l2_tag_array_nway_if
  import cache_def::*;
#(
  parameter int WAYS  = DEF_WAYS,
  parameter int SETS  = DEF_SETS,
  parameter int TAG_W = DEF_TAG_W
) ();

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  logic             req_valid_i;
  logic             req_ready_o;
  logic [IDX_W-1:0] req_index_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             req_we_i;
  logic [TAG_W+1:0] req_wdata_i;

  logic             rsp_valid_o;
  logic             rsp_hit_o;
  logic [WAY_W-1:0] rsp_way_o;
  logic [TAG_W+1:0] rsp_entry_o;
  logic             rsp_full_o;
  logic [WAY_W-1:0] rsp_victim_o;

  logic             flush_i;
  logic             flush_busy_o;
  logic             flush_done_o;

  modport master (
    output req_valid_i, req_index_i, req_tag_i, req_we_i, req_wdata_i, flush_i,
    input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_entry_o,
           rsp_full_o, rsp_victim_o, flush_busy_o, flush_done_o
  );

  modport slave (
    input  req_valid_i, req_index_i, req_tag_i, req_we_i, req_wdata_i, flush_i,
    output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_entry_o,
           rsp_full_o, rsp_victim_o, flush_busy_o, flush_done_o
  );

endinterface

// File: rtl/l2_tag_array_nway_victim_sel.sv
// Replacement candidate for one set: lowest invalid way, otherwise a tree pseudo-LRU walk
// (L2_TAG_PLRU_EN defined) or the set's round-robin pointer (default).
module l2_tag_victim_sel #(
  parameter int WAYS   = 8,
  parameter int REPL_W = WAYS - 1,
  parameter int WAY_W  = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]   valid,
  input  logic [REPL_W-1:0] repl,
  output logic [WAY_W-1:0]  victim,
  output logic              full
);

  assign full = &valid;

`ifdef L2_TAG_PLRU_EN
  logic [WAY_W-1:0] node;
  logic             dir;

  // Tree bit set means the colder half is the upper one; children of node n are 2n+1 / 2n+2.
  always_comb begin
    victim = '0;
    node   = '0;
    dir    = 1'b0;
    if (!full) begin
      for (int w = WAYS - 1; w >= 0; w--)
        if (!valid[w]) victim = WAY_W'(w);
    end else begin
      for (int l = 0; l < WAY_W; l++) begin
        dir    = repl[node];
        victim = (victim << 1) | WAY_W'(dir);
        node   = (node << 1) + WAY_W'(1) + WAY_W'(dir);
      end
    end
  end
`else
  always_comb begin
    victim = '0;
    if (!full) begin
      for (int w = WAYS - 1; w >= 0; w--)
        if (!valid[w]) victim = WAY_W'(w);
    end else begin
      victim = repl[WAY_W-1:0];
    end
  end
`endif

endmodule

// File: rtl/l2_tag_array_nway.sv
// L2 tag array: single-cycle lookup/update with a registered response and a one-set-per-cycle flush.
// Replacement is tree pseudo-LRU when L2_TAG_PLRU_EN is defined, per-set round-robin otherwise.
//
// state    | meaning
// ST_IDLE  | accepting lookups/writes unless flush_i is raised
// ST_FLUSH | clearing valid bits and replacement state of set flush_idx, one set per cycle
module l2_tag_array_nway
  import cache_def::*;
#(
  parameter int WAYS  = DEF_WAYS,
  parameter int SETS  = DEF_SETS,
  parameter int TAG_W = DEF_TAG_W
) (
  input logic               clk_i,
  input logic               rst_i,
  l2_tag_array_nway_if.slave bus
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
`ifdef L2_TAG_PLRU_EN
  localparam int REPL_W = WAYS - 1;
`else
  localparam int REPL_W = WAY_W;
`endif

  tag_state_e       state;
  logic [IDX_W-1:0] flush_idx;

  // Valid and replacement state need reset/flush; dirty+tag behave like plain RAM.
  logic [WAYS-1:0]   valid_q [SETS];
  logic [REPL_W-1:0] repl_q  [SETS];
  logic [TAG_W:0]    dt_q    [SETS][WAYS];

  logic             rsp_valid_q, rsp_hit_q, rsp_full_q, busy_q, done_q;
  logic [WAY_W-1:0] rsp_way_q, rsp_victim_q;
  logic [TAG_W+1:0] rsp_entry_q;

  logic [IDX_W-1:0]  idx;
  logic [WAYS-1:0]   set_valid, hit_vec;
  logic [REPL_W-1:0] set_repl, repl_next;
  logic [WAY_W-1:0]  hit_way, victim, sel_way;
  logic              hit, full, req_fire, repl_upd;
  cache_tag_type     wr_entry, rd_entry;

  assign idx       = bus.req_index_i;
  assign set_valid = valid_q[idx];
  assign set_repl  = repl_q[idx];
  assign wr_entry  = bus.req_wdata_i;

  assign bus.req_ready_o = (state == ST_IDLE) && !bus.flush_i;
  assign req_fire        = bus.req_valid_i && bus.req_ready_o;

  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < WAYS; w++)
      hit_vec[w] = set_valid[w] && (dt_q[idx][w][TAG_W-1:0] == bus.req_tag_i);
  end

  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (hit_vec[w]) hit_way = WAY_W'(w);
  end

  assign hit      = |hit_vec;
  assign sel_way  = hit ? hit_way : victim;
  assign rd_entry = {set_valid[sel_way], dt_q[idx][sel_way]};

  l2_tag_victim_sel #(.WAYS(WAYS), .REPL_W(REPL_W), .WAY_W(WAY_W)) u_victim_sel (
    .valid  (set_valid),
    .repl   (set_repl),
    .victim (victim),
    .full   (full)
  );

`ifdef L2_TAG_PLRU_EN
  // Point every node on the path to the accessed way toward the other half.
  function automatic logic [REPL_W-1:0] plru_touch(input logic [REPL_W-1:0] cur,
                                                   input logic [WAY_W-1:0]  way);
    logic [REPL_W-1:0] nxt;
    logic [WAY_W-1:0]  node, path;
    logic              dir;
    nxt  = cur;
    node = '0;
    path = way;
    for (int l = 0; l < WAY_W; l++) begin
      dir       = path[WAY_W-1];
      nxt[node] = ~dir;
      node      = (node << 1) + WAY_W'(1) + WAY_W'(dir);
      path      = path << 1;
    end
    return nxt;
  endfunction

  assign repl_upd  = req_fire && (bus.req_we_i || hit);
  assign repl_next = plru_touch(set_repl, sel_way);
`else
  assign repl_upd  = req_fire && bus.req_we_i && !hit && full;
  assign repl_next = set_repl + REPL_W'(1);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      flush_idx    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_full_q   <= 1'b0;
      rsp_way_q    <= '0;
      rsp_victim_q <= '0;
      rsp_entry_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        repl_q[s]  <= '0;
      end
    end else begin
      rsp_valid_q <= req_fire;
      done_q      <= 1'b0;
      if (req_fire) begin
        rsp_hit_q    <= hit;
        rsp_way_q    <= sel_way;
        rsp_full_q   <= full;
        rsp_victim_q <= victim;
        rsp_entry_q  <= bus.req_we_i ? bus.req_wdata_i : rd_entry;
        if (bus.req_we_i) valid_q[idx][sel_way] <= wr_entry.valid;
      end
      if (repl_upd) repl_q[idx] <= repl_next;
      case (state)
        ST_IDLE: begin
          if (bus.flush_i) begin
            state     <= ST_FLUSH;
            flush_idx <= '0;
            busy_q    <= 1'b1;
          end
        end
        ST_FLUSH: begin
          valid_q[flush_idx] <= '0;
          repl_q[flush_idx]  <= '0;
          if (flush_idx == IDX_W'(SETS - 1)) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            flush_idx <= flush_idx + IDX_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (req_fire && bus.req_we_i)
      dt_q[idx][sel_way] <= {wr_entry.dirty, wr_entry.tag};
  end

  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_hit_o    = rsp_hit_q;
  assign bus.rsp_way_o    = rsp_way_q;
  assign bus.rsp_entry_o  = rsp_entry_q;
  assign bus.rsp_full_o   = rsp_full_q;
  assign bus.rsp_victim_o = rsp_victim_q;
  assign bus.flush_busy_o = busy_q;
  assign bus.flush_done_o = done_q;

endmodule

// File: tb/tb_l2_tag_array_nway.sv
// Bench for l2_tag_array_nway: directed scenarios and randomized traffic checked against a
// behavioural set/way model (tree PLRU or round-robin, following L2_TAG_PLRU_EN).
module tb_l2_tag_array_nway;
  import cache_def::*;

  localparam int WAYS  = 8;
  localparam int SETS  = 1024;
  localparam int TAG_W = 18;
  localparam int IDX_W = $clog2(SETS);

  typedef struct {
    logic             v;
    logic             hit;
    int               way;
    logic [TAG_W+1:0] entry;
    logic             full;
    int               victim;
  } rsp_s;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  l2_tag_array_nway_if #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) bus ();

  l2_tag_array_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: per-set valid/dirty/tag, heap-ordered PLRU bits (1..WAYS-1), RR pointer.
  bit m_valid [SETS][WAYS];
  bit m_dirty [SETS][WAYS];
  int m_tag   [SETS][WAYS];
  bit m_tree  [SETS][WAYS];
  int m_ptr   [SETS];

  function automatic void model_clear_all();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_tree[s][w]  = 0;
      end
    end
  endfunction

  function automatic int model_victim(input int s);
    int lo, size, node;
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[s][w]) return w;
`ifdef L2_TAG_PLRU_EN
    lo = 0; size = WAYS; node = 1;
    while (size > 1) begin
      size = size / 2;
      if (m_tree[s][node]) begin lo += size; node = 2 * node + 1; end
      else node = 2 * node;
    end
    return lo;
`else
    lo = 0; size = 0; node = 0;
    return m_ptr[s];
`endif
  endfunction

  function automatic void model_touch(input int s, input int way);
    int lo, size, node;
    lo = 0; size = WAYS; node = 1;
    while (size > 1) begin
      size = size / 2;
      if (way < lo + size) begin m_tree[s][node] = 1; node = 2 * node; end
      else begin m_tree[s][node] = 0; lo += size; node = 2 * node + 1; end
    end
  endfunction

  function automatic rsp_s model_access(input int idx, input int tag, input bit we,
                                        input logic [TAG_W+1:0] wd);
    rsp_s e;
    e.v = 1; e.hit = 0; e.way = 0; e.full = 1;
    for (int w = WAYS - 1; w >= 0; w--)
      if (m_valid[idx][w] && m_tag[idx][w] == tag) begin e.hit = 1; e.way = w; end
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[idx][w]) e.full = 0;
    e.victim = model_victim(idx);
    if (!e.hit) e.way = e.victim;
    e.entry = we ? wd : {1'b1, m_dirty[idx][e.way], TAG_W'(m_tag[idx][e.way])};
    if (we) begin
      m_valid[idx][e.way] = wd[TAG_W+1];
      m_dirty[idx][e.way] = wd[TAG_W];
      m_tag[idx][e.way]   = int'(wd[TAG_W-1:0]);
`ifdef L2_TAG_PLRU_EN
      model_touch(idx, e.way);
`else
      if (!e.hit && e.full) m_ptr[idx] = (m_ptr[idx] + 1) % WAYS;
`endif
    end else if (e.hit) begin
`ifdef L2_TAG_PLRU_EN
      model_touch(idx, e.way);
`endif
    end
    return e;
  endfunction

  // Drive one request at edge+1, let it be accepted on the next edge, sample at edge+1.
  task automatic do_req(input int idx, input int tag, input bit we, input logic [TAG_W+1:0] wd,
                        output rsp_s obs, output logic rdy);
    bus.req_valid_i = 1'b1;
    bus.req_index_i = IDX_W'(idx);
    bus.req_tag_i   = TAG_W'(tag);
    bus.req_we_i    = we;
    bus.req_wdata_i = wd;
    #1 rdy = bus.req_ready_o;
    @(posedge clk_i); #1;
    obs.v      = bus.rsp_valid_o;
    obs.hit    = bus.rsp_hit_o;
    obs.way    = int'(bus.rsp_way_o);
    obs.entry  = bus.rsp_entry_o;
    obs.full   = bus.rsp_full_o;
    obs.victim = int'(bus.rsp_victim_o);
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    bus.req_valid_i = 0; bus.req_index_i = '0; bus.req_tag_i = '0;
    bus.req_we_i = 0; bus.req_wdata_i = '0; bus.flush_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    vectors++;
    if ({bus.rsp_valid_o, bus.rsp_hit_o, bus.rsp_full_o, bus.flush_busy_o, bus.flush_done_o} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 00000", {bus.rsp_valid_o, bus.rsp_hit_o,
               bus.rsp_full_o, bus.flush_busy_o, bus.flush_done_o});
    end
    vectors++;
    if (bus.rsp_way_o !== '0 || bus.rsp_victim_o !== '0 || bus.rsp_entry_o !== '0) begin
      miscompares++;
      $display("FAIL reset_fields got way=%0d victim=%0d entry=%0h want 0 0 0",
               bus.rsp_way_o, bus.rsp_victim_o, bus.rsp_entry_o);
    end
    rst_i = 1'b0;
    #1;
    vectors++;
    if (bus.req_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready got %b want 1", bus.req_ready_o);
    end
    model_clear_all();
  endtask

  task automatic test_read_after_reset();
    rsp_s o, e;
    logic rdy;
    e = model_access(5, 'h123, 0, '0);
    do_req(5, 'h123, 0, '0, o, rdy);
    vectors++;
    if (o.v !== 1'b1 || o.hit !== 1'b0 || o.victim !== 0 || o.full !== 1'b0 || e.hit) begin
      miscompares++;
      $display("FAIL empty_read got v=%b hit=%b victim=%0d full=%b want 1 0 0 0",
               o.v, o.hit, o.victim, o.full);
    end
  endtask

  task automatic test_back_to_back();
    rsp_s o, e;
    logic rdy;
    logic [TAG_W+1:0] ent;
    ent = {1'b1, 1'b0, TAG_W'('h123)};
    e = model_access(5, 'h123, 1, ent);
    do_req(5, 'h123, 1, ent, o, rdy);
    vectors++;
    if (o.hit !== 1'b0 || o.way !== 0 || e.way !== 0) begin
      miscompares++;
      $display("FAIL raw_write got hit=%b way=%0d want 0 0", o.hit, o.way);
    end
    e = model_access(5, 'h123, 0, '0);
    do_req(5, 'h123, 0, '0, o, rdy);
    vectors++;
    if (o.v !== 1'b1 || o.hit !== 1'b1 || o.way !== 0 || o.entry !== ent) begin
      miscompares++;
      $display("FAIL raw_read got v=%b hit=%b way=%0d entry=%0h want 1 1 0 %0h",
               o.v, o.hit, o.way, o.entry, ent);
    end
  endtask

  task automatic test_replacement();
    rsp_s o, e;
    logic rdy;
    int bad_fill, bad_touch, want2;
    bad_fill = 0; bad_touch = 0;
    for (int t = 0; t < WAYS; t++) begin
      e = model_access(7, t, 1, {1'b1, 1'b0, TAG_W'(t)});
      do_req(7, t, 1, {1'b1, 1'b0, TAG_W'(t)}, o, rdy);
      if (o.way !== t || o.hit !== 1'b0) bad_fill++;
    end
    vectors++;
    if (bad_fill != 0) begin
      miscompares++;
      $display("FAIL fill_ways got %0d misplaced writes want 0", bad_fill);
    end
    for (int t = 0; t < WAYS; t++) begin
      e = model_access(7, t, 0, '0);
      do_req(7, t, 0, '0, o, rdy);
      if (o.way !== t || o.hit !== 1'b1 || o.full !== 1'b1) bad_touch++;
    end
    vectors++;
    if (bad_touch != 0) begin
      miscompares++;
      $display("FAIL touch_ways got %0d bad reads want 0", bad_touch);
    end
    e = model_access(7, 8, 1, {1'b1, 1'b0, TAG_W'(8)});
    do_req(7, 8, 1, {1'b1, 1'b0, TAG_W'(8)}, o, rdy);
    vectors++;
    if (o.full !== 1'b1 || o.way !== 0 || o.hit !== 1'b0) begin
      miscompares++;
      $display("FAIL replace_first got full=%b way=%0d hit=%b want 1 0 0", o.full, o.way, o.hit);
    end
`ifdef L2_TAG_PLRU_EN
    want2 = 4;
`else
    want2 = 1;
`endif
    e = model_access(7, 9, 1, {1'b1, 1'b1, TAG_W'(9)});
    do_req(7, 9, 1, {1'b1, 1'b1, TAG_W'(9)}, o, rdy);
    vectors++;
    if (o.way !== want2 || e.way != want2) begin
      miscompares++;
      $display("FAIL replace_second got way=%0d (model %0d) want %0d", o.way, e.way, want2);
    end
  endtask

  task automatic test_random();
    rsp_s o, e;
    logic rdy;
    int idx, tag;
    bit we;
    logic [TAG_W+1:0] wd;
    for (int n = 0; n < 500; n++) begin
      idx = ($urandom_range(0, 4) == 4) ? SETS - 1 : int'($urandom_range(0, 3));
      tag = int'($urandom_range(0, 10));
      we  = ($urandom_range(0, 9) < 4);
      wd  = {($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)), TAG_W'(tag)};
      e = model_access(idx, tag, we, wd);
      do_req(idx, tag, we, wd, o, rdy);
      vectors++;
      if (rdy !== 1'b1 || o.v !== 1'b1) begin
        miscompares++;
        $display("FAIL rand_handshake n=%0d got ready=%b rsp_valid=%b want 1 1", n, rdy, o.v);
      end
      vectors++;
      if (o.hit !== e.hit || o.full !== e.full || o.victim !== e.victim) begin
        miscompares++;
        $display("FAIL rand_lookup n=%0d idx=%0d tag=%0d got hit=%b full=%b victim=%0d want %b %b %0d",
                 n, idx, tag, o.hit, o.full, o.victim, e.hit, e.full, e.victim);
      end
      if (we || e.hit) begin
        vectors++;
        if (o.way !== e.way || o.entry !== e.entry) begin
          miscompares++;
          $display("FAIL rand_way n=%0d idx=%0d got way=%0d entry=%0h want %0d %0h",
                   n, idx, o.way, o.entry, e.way, e.entry);
        end
      end
    end
  endtask

  task automatic test_flush();
    rsp_s o, e;
    logic rdy;
    int busy_cnt, done_cnt, rdy_bad, done_bad;
    busy_cnt = 0; done_cnt = 0; rdy_bad = 0; done_bad = 0;
    bus.flush_i = 1'b1;
    #1;
    vectors++;
    if (bus.req_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ready_same_cycle got %b want 0", bus.req_ready_o);
    end
    @(posedge clk_i); #1;
    bus.flush_i = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      bus.flush_i = (c == 500);
      if (bus.flush_busy_o) begin
        busy_cnt++;
        if (bus.req_ready_o !== 1'b0) rdy_bad++;
      end
      if (bus.flush_done_o) begin
        done_cnt++;
        if (bus.flush_busy_o) done_bad++;
      end
      @(posedge clk_i); #1;
    end
    bus.flush_i = 1'b0;
    model_clear_all();
    vectors++;
    if (busy_cnt != SETS) begin
      miscompares++;
      $display("FAIL flush_busy_cycles got %0d want %0d", busy_cnt, SETS);
    end
    vectors++;
    if (done_cnt != 1 || done_bad != 0) begin
      miscompares++;
      $display("FAIL flush_done_pulse got %0d pulses (%0d while busy) want 1 (0)", done_cnt, done_bad);
    end
    vectors++;
    if (rdy_bad != 0) begin
      miscompares++;
      $display("FAIL flush_ready_low got %0d busy cycles with ready want 0", rdy_bad);
    end
    e = model_access(7, 3, 0, '0);
    do_req(7, 3, 0, '0, o, rdy);
    vectors++;
    if (o.hit !== 1'b0 || o.full !== 1'b0 || o.victim !== e.victim) begin
      miscompares++;
      $display("FAIL flush_cleared got hit=%b full=%b victim=%0d want 0 0 %0d",
               o.hit, o.full, o.victim, e.victim);
    end
  endtask

  task automatic test_flush_priority();
    int done_seen;
    done_seen = 0;
    bus.flush_i     = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_index_i = IDX_W'(7);
    bus.req_tag_i   = TAG_W'(3);
    bus.req_wdata_i = {1'b1, 1'b0, TAG_W'(3)};
    #1;
    vectors++;
    if (bus.req_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_ready got %b want 0", bus.req_ready_o);
    end
    @(posedge clk_i); #1;
    bus.flush_i = 1'b0; bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0;
    vectors++;
    if (bus.rsp_valid_o !== 1'b0 || bus.flush_busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_no_rsp got rsp_valid=%b busy=%b want 0 1", bus.rsp_valid_o, bus.flush_busy_o);
    end
    for (int c = 0; c < 1100 && done_seen == 0; c++) begin
      if (bus.rsp_valid_o) done_seen = -1;
      if (bus.flush_done_o) done_seen = 1;
      @(posedge clk_i); #1;
    end
    vectors++;
    if (done_seen != 1) begin
      miscompares++;
      $display("FAIL prio_flush_done got status %0d want 1 (timeout or stray response)", done_seen);
    end
    model_clear_all();
  endtask

  task automatic test_reset_mid_flush();
    rsp_s o, e;
    logic rdy;
    int done_cnt, busy_cnt;
    done_cnt = 0; busy_cnt = 0;
    bus.flush_i = 1'b1;
    @(posedge clk_i); #1;
    bus.flush_i = 1'b0;
    repeat (100) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    vectors++;
    if (bus.flush_busy_o !== 1'b0 || bus.flush_done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_flush_reset got busy=%b done=%b want 0 0", bus.flush_busy_o, bus.flush_done_o);
    end
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_clear_all();
    for (int c = 0; c < 1200; c++) begin
      if (bus.flush_done_o) done_cnt++;
      if (bus.flush_busy_o) busy_cnt++;
      @(posedge clk_i); #1;
    end
    vectors++;
    if (done_cnt != 0 || busy_cnt != 0) begin
      miscompares++;
      $display("FAIL mid_flush_aborted got done=%0d busy=%0d cycles want 0 0", done_cnt, busy_cnt);
    end
    e = model_access(5, 'h123, 0, '0);
    do_req(5, 'h123, 0, '0, o, rdy);
    vectors++;
    if (rdy !== 1'b1 || o.hit !== e.hit || o.full !== e.full) begin
      miscompares++;
      $display("FAIL post_reset_read got ready=%b hit=%b full=%b want 1 %b %b",
               rdy, o.hit, o.full, e.hit, e.full);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_after_reset();
    test_back_to_back();
    test_replacement();
    test_random();
    test_flush();
    test_flush_priority();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/l2_tag_array_nway.md
L2_TAG_ARRAY_NWAY -- requirements
Module: l2_tag_array_nway

Interface
REQ-001 SHALL have parameter WAYS, 8, associativity; power of two, 2..16.
REQ-002 SHALL have parameter SETS, 1024, number of sets; power of two.
REQ-003 SHALL have parameter TAG_W, 18, tag width in bits; IDX_W = clog2(SETS), WAY_W = clog2(WAYS) are derived.
REQ-004 SHALL have ports: clk_i  in  1  clock; rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: req_valid_i in 1 request; req_ready_o out 1 accept; req_index_i in IDX_W set; req_tag_i in TAG_W lookup tag; req_we_i in 1 write entry; req_wdata_i in TAG_W+2 entry {valid, dirty, tag}.
REQ-006 SHALL have ports: rsp_valid_o out 1; rsp_hit_o out 1; rsp_way_o out WAY_W hit or written way; rsp_entry_o out TAG_W+2 entry read from that way; rsp_full_o out 1 all ways valid; rsp_victim_o out WAY_W replacement candidate.
REQ-007 SHALL have ports: flush_i in 1 start invalidate-all; flush_busy_o out 1; flush_done_o out 1 one-cycle pulse.

Function
REQ-008 SHALL accept a request on a rising edge with req_valid_i and req_ready_o both high; req_ready_o = (state IDLE) and not flush_i.
REQ-009 SHALL present the response exactly one cycle after acceptance, rsp_valid_o high for that one cycle; responses have no backpressure.
REQ-010 SHALL compute hit per way as valid and tag equal; with several hits, the lowest way index wins.
REQ-011 SHALL compute the victim as the lowest-index invalid way; if the set is full, the replacement policy (REQ-020/021) chooses it.
REQ-012 SHALL, on an accepted write, store req_wdata_i into the hit way, otherwise into the victim way, at the accept edge; rsp_way_o reports the way written.
REQ-013 SHALL, for every accepted request, update replacement state to mark rsp_way_o most recently used; a read miss updates nothing.
REQ-014 SHALL make the array write visible to a request accepted on the next cycle (back-to-back same-index read-after-write returns new data).
REQ-015 SHALL implement FSM IDLE -> FLUSH on flush_i in IDLE; FLUSH clears valid and replacement state of one set per cycle, index 0..SETS-1; after the last set -> IDLE with flush_done_o pulsed in the first IDLE cycle.
REQ-016 SHALL hold flush_busy_o high exactly in FLUSH (SETS cycles); flush_i while busy is ignored.
REQ-017 SHALL give flush_i priority over a simultaneous req_valid_i: the request is not accepted and no response is produced.

Reset
REQ-018 SHALL, on rst_i, clear all valid bits and all replacement state, enter IDLE, and drive rsp_valid_o, rsp_hit_o, rsp_full_o, flush_busy_o, flush_done_o to 0 and rsp_way_o, rsp_victim_o, rsp_entry_o to 0.
REQ-019 SHALL abort an in-progress flush on reset with no flush_done_o pulse; tag fields need not be cleared.

Configuration
REQ-020 SHALL, with L2_TAG_PLRU_EN defined, use tree pseudo-LRU with WAYS-1 bits per set; the victim follows the tree bits away from recent accesses.
REQ-021 SHALL, without L2_TAG_PLRU_EN, use a per-set WAY_W round-robin pointer as victim when full, incremented modulo WAYS on each allocation into a full set.

Structure
REQ-022 SHALL take cache_tag_type {valid, dirty, tag} and the default parameter constants from the shared package cache_def.
REQ-023 SHALL place victim selection (invalid-first, then PLRU or round-robin) in sub-module l2_tag_victim_sel.

Verification (WAYS=8, SETS=1024, TAG_W=18, L2_TAG_PLRU_EN defined unless stated)
REQ-024 SHALL cover: after reset, read index 5 tag 0x123 -> rsp_hit_o 0, rsp_victim_o 0, rsp_full_o 0.
REQ-025 SHALL cover: write index 5 {1,0,0x123}, read the same on the next cycle -> rsp_hit_o 1, rsp_way_o 0, rsp_entry_o {1,0,0x123}.
REQ-026 SHALL cover: fill index 7 with tags 0..7, touch ways 0..7 in order, write tag 8 -> rsp_full_o 1, written way 0; without the macro, ways 0 then 1 are replaced on successive allocations.
REQ-027 SHALL cover: flush_i pulse -> flush_busy_o high 1024 cycles, flush_done_o one pulse, req_ready_o low throughout; a later read of index 7 tag 3 -> rsp_hit_o 0.
REQ-028 SHALL cover: flush_i and req_valid_i in the same cycle -> no rsp_valid_o; and rst_i at flush cycle 100 -> flush_busy_o 0 and no flush_done_o pulse.
